// File: rtl/gray_decode_arbiter_pkg.sv
// gray_arb_pkg: shared types and default constants for gray_decode_arbiter.
//   arb_state_e  - arbiter/sequencer FSM state (also exported on the debug port)
//   DEF_N_REQ    - default number of requesters
//   DEF_W        - default Gray/binary word width
package gray_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 3;

endpackage

// File: rtl/gray_decode_arbiter_if.sv
// gray_decode_arbiter_if: bundle of requester-side and result-side signals.
//   req       - per-requester request level
//   gray_in   - packed Gray codes, requester i at [i*W +: W]
//   gnt       - one-hot, one-cycle grant pulse
//   out_valid / out_ready / out_bin / out_id - decoded result port
//   busy      - arbiter is not idle
//
// Handshake: the result port is strict valid/ready. Once out_valid is high,
// out_bin and out_id stay constant until a rising edge with out_valid and
// out_ready both high; that edge completes the transfer. out_ready may be
// driven freely and has no effect while out_valid is low. The requester side
// is level based: req[i] and its slice are held until gnt[i] is seen.
//
// Modports: slave = the arbiter, master = the environment driving it.
interface gray_decode_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 3
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] gray_in;
  logic [N_REQ-1:0]   gnt;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_bin;
  logic [IDW-1:0]     out_id;
  logic               busy;

  modport slave (
    input  req, gray_in, out_ready,
    output gnt, out_valid, out_bin, out_id, busy
  );

  modport master (
    output req, gray_in, out_ready,
    input  gnt, out_valid, out_bin, out_id, busy
  );

endinterface

// File: rtl/gray_decode_arbiter_gray2bin.sv
// gray2bin_w: combinational Gray-to-binary decoder.
//   gray - W-bit Gray code in
//   bin  - W-bit binary out; bin[i] = XOR of gray[W-1:i], MSB passes through
module gray2bin_w #(
  parameter int W = 3
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Running XOR from the MSB downward; a scalar accumulator keeps the
  // chain free of self-referencing vector bits.
  always_comb begin
    logic acc;
    acc = 1'b0;
    bin = '0;
    for (int i = W - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/gray_decode_arbiter.sv
// gray_decode_arbiter: round-robin arbiter sharing one Gray decoder among
// N_REQ requesters. A grant latches the winner's code, the next cycle
// decodes it into the output registers, and the result is held on a
// valid/ready port until accepted.
//   clk, rst   - clock, asynchronous active-high reset
//   bus        - slave side of gray_decode_arbiter_if (requests, grants,
//                result port, busy)
//   state_dbg  - current FSM state
module gray_decode_arbiter
  import gray_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int W     = DEF_W,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_decode_arbiter_if.slave  bus,
  output arb_state_e            state_dbg
);

  arb_state_e       state;
  logic [N_REQ-1:0] gnt_r;
  logic             out_valid_r;
  logic [W-1:0]     out_bin_r;
  logic [IDW-1:0]   out_id_r;
  logic             busy_r;

  logic [W-1:0]     g_lat;
  logic [IDW-1:0]   id_lat;
  logic [IDW-1:0]   last_r;

  logic [IDW-1:0]   win_idx;
  logic [N_REQ-1:0] win_oh;
  logic [W-1:0]     win_gray;
  logic [W-1:0]     dec_bin;

  // Search starts one past the previous winner and wraps, so the last
  // winner has the lowest priority on the next pass.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDW-1:0]   last);
    logic found;
    int   idx;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && r[idx]) begin
        rr_pick = IDW'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    win_idx  = rr_pick(bus.req, last_r);
    win_oh   = '0;
    win_gray = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDW'(i)) begin
        win_oh[i] = 1'b1;
        win_gray  = bus.gray_in[i*W +: W];
      end
    end
  end

  gray2bin_w #(.W(W)) u_dec (
    .gray (g_lat),
    .bin  (dec_bin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt_r       <= '0;
      out_valid_r <= 1'b0;
      out_bin_r   <= '0;
      out_id_r    <= '0;
      busy_r      <= 1'b0;
      g_lat       <= '0;
      id_lat      <= '0;
      last_r      <= IDW'(N_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          gnt_r <= '0;
          if (|bus.req) begin
            gnt_r  <= win_oh;
            g_lat  <= win_gray;
            id_lat <= win_idx;
            last_r <= win_idx;
            busy_r <= 1'b1;
            state  <= ST_CONV;
          end
        end
        ST_CONV: begin
          gnt_r       <= '0;
          out_bin_r   <= dec_bin;
          out_id_r    <= id_lat;
          out_valid_r <= 1'b1;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          // out_bin/out_id are left as-is after the transfer.
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          gnt_r       <= '0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_bin   = out_bin_r;
  assign bus.out_id    = out_id_r;
  assign bus.busy      = busy_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// tb_gray_decode_arbiter: directed tables, multi-cycle corner sequences and
// a randomized run against a transaction-level reference model.
module tb_gray_decode_arbiter;
  import gray_arb_pkg::*;

  localparam int N   = DEF_N_REQ;
  localparam int W   = DEF_W;
  localparam int IDW = $clog2(N);

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  arb_state_e state_dbg;

  always #5 clk = ~clk;

  gray_decode_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  gray_decode_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0]   exp_q[$];
  logic [IDW-1:0] exp_id_q[$];

  typedef struct {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
  } dec_vec_t;

  typedef struct {
    int           id;
    logic [W-1:0] gray;
    logic [W-1:0] bin;
  } rr_vec_t;

  dec_vec_t dec_tab[8];
  rr_vec_t  rr_tab[5];

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] g);
    bus.gray_in[i*W +: W] = g;
  endtask

  function automatic logic [N-1:0] onehot(input int id);
    logic [N-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Gray -> binary as the XOR of all right shifts of the code.
  function automatic logic [W-1:0] model_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One full request/decode/accept transaction from IDLE back to IDLE.
  task automatic do_txn(input int id, input logic [W-1:0] g,
                        input logic [W-1:0] exp_bin, input string tag);
    bus.req       = '0;
    bus.req[id]   = 1'b1;
    set_slice(id, g);
    bus.out_ready = 1'b0;
    tick();
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(onehot(id)));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    bus.req = '0;
    tick();
    chk({tag, "_gnt_drop"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_bin"}, 32'(bus.out_bin), 32'(exp_bin));
    chk({tag, "_id"}, 32'(bus.out_id), 32'(id));
    bus.out_ready = 1'b1;
    tick();
    chk({tag, "_accept"}, 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reference model state for the randomized phase
    int             m_last;
    bit             m_pending;
    int             m_grant_cyc;
    int             m_free;
    logic [N-1:0]   exp_gnt;
    logic [W-1:0]   g;
    bit             exp_valid;

    dec_tab[0] = '{3'b000, 3'd0};
    dec_tab[1] = '{3'b001, 3'd1};
    dec_tab[2] = '{3'b011, 3'd2};
    dec_tab[3] = '{3'b010, 3'd3};
    dec_tab[4] = '{3'b110, 3'd4};
    dec_tab[5] = '{3'b111, 3'd5};
    dec_tab[6] = '{3'b101, 3'd6};
    dec_tab[7] = '{3'b100, 3'd7};

    rr_tab[0] = '{0, 3'b000, 3'd0};
    rr_tab[1] = '{1, 3'b001, 3'd1};
    rr_tab[2] = '{2, 3'b011, 3'd2};
    rr_tab[3] = '{3, 3'b010, 3'd3};
    rr_tab[4] = '{0, 3'b000, 3'd0};

    // ---- reset state ----
    rst           = 1'b1;
    bus.req       = '0;
    bus.gray_in   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_bin", 32'(bus.out_bin), 32'd0);
    chk("rst_id", 32'(bus.out_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    rst = 1'b0;

    // ---- single request: slice0 = 110 -> 100 ----
    do_txn(0, 3'b110, 3'b100, "single");

    // ---- decode sweep on requester 2 ----
    for (int i = 0; i < 8; i++)
      do_txn(2, dec_tab[i].gray, dec_tab[i].bin, $sformatf("sweep%0d", i));

    // ---- round-robin with everyone requesting ----
    do_reset();
    for (int i = 0; i < N; i++) set_slice(i, rr_tab[i].gray);
    bus.req       = '1;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("rr%0d_gnt", j), 32'(bus.gnt), 32'(onehot(rr_tab[j].id)));
      tick();
      chk($sformatf("rr%0d_valid", j), 32'(bus.out_valid), 32'd1);
      chk($sformatf("rr%0d_bin", j), 32'(bus.out_bin), 32'(rr_tab[j].bin));
      chk($sformatf("rr%0d_id", j), 32'(bus.out_id), 32'(rr_tab[j].id));
      tick();
      chk($sformatf("rr%0d_accept", j), 32'(bus.out_valid), 32'd0);
    end
    bus.req       = '0;
    bus.out_ready = 1'b0;

    // ---- backpressure: result 101 held 5 cycles, requester 1 waits ----
    bus.req    = '0;
    bus.req[2] = 1'b1;
    set_slice(2, 3'b111);
    tick();
    chk("bp_gnt2", 32'(bus.gnt), 32'(onehot(2)));
    bus.req = '0;
    tick();
    chk("bp_valid_rise", 32'(bus.out_valid), 32'd1);
    bus.req[1] = 1'b1;
    set_slice(1, 3'b011);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_hold%0d_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_bin", c), 32'(bus.out_bin), 32'b101);
      chk($sformatf("bp_hold%0d_id", c), 32'(bus.out_id), 32'd2);
      chk($sformatf("bp_hold%0d_gnt", c), 32'(bus.gnt), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_accept_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_accept_gnt", 32'(bus.gnt), 32'd0);
    tick();
    chk("bp_next_gnt1", 32'(bus.gnt), 32'(onehot(1)));
    bus.req = '0;
    tick();
    chk("bp_next_bin", 32'(bus.out_bin), 32'd2);
    chk("bp_next_id", 32'(bus.out_id), 32'd1);
    tick();
    chk("bp_next_accept", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // ---- asynchronous reset while holding a result ----
    bus.req    = '0;
    bus.req[0] = 1'b1;
    set_slice(0, 3'b011);
    tick();
    bus.req = '0;
    tick();
    chk("mid_valid_before", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_bin", 32'(bus.out_bin), 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    rst     = 1'b0;
    bus.req = '1;
    tick();
    chk("mid_after_gnt0", 32'(bus.gnt), 32'(onehot(0)));
    bus.req = '0;
    tick();
    chk("mid_after_id", 32'(bus.out_id), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // ---- wrap priority: after requester 3, 1001 -> 0 then 3 ----
    do_txn(3, 3'b010, 3'd3, "wrap3");
    bus.req = 4'b1001;
    set_slice(0, 3'b001);
    set_slice(3, 3'b011);
    tick();
    chk("wrap_gnt0", 32'(bus.gnt), 32'(onehot(0)));
    tick();
    chk("wrap_id0", 32'(bus.out_id), 32'd0);
    chk("wrap_bin0", 32'(bus.out_bin), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("wrap_gnt3", 32'(bus.gnt), 32'(onehot(3)));
    bus.req = '0;
    tick();
    chk("wrap_id3", 32'(bus.out_id), 32'd3);
    chk("wrap_bin3", 32'(bus.out_bin), 32'd2);
    tick();
    chk("wrap_accept", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // ---- randomized run against the reference model ----
    do_reset();
    m_last      = N - 1;
    m_pending   = 1'b0;
    m_grant_cyc = 0;
    m_free      = 0;
    exp_q.delete();
    exp_id_q.delete();
    for (int i = 0; i < N; i++) begin
      bus.req[i] = ($urandom_range(0, 1) == 1);
      g = W'($urandom);
      set_slice(i, g);
    end
    bus.out_ready = ($urandom_range(0, 3) != 0);

    for (int cyc = 0; cyc < 400; cyc++) begin
      // What the coming edge should do, from the current inputs.
      exp_gnt = '0;
      if (m_pending && cyc >= m_grant_cyc + 2 && bus.out_ready) begin
        void'(exp_q.pop_front());
        void'(exp_id_q.pop_front());
        m_pending = 1'b0;
        m_free    = cyc + 1;
      end else if (!m_pending && cyc >= m_free && bus.req != '0) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (exp_gnt == '0 && bus.req[idx]) begin
            exp_gnt = onehot(idx);
            m_last  = idx;
          end
        end
        exp_q.push_back(model_bin(bus.gray_in[m_last*W +: W]));
        exp_id_q.push_back(IDW'(m_last));
        m_pending   = 1'b1;
        m_grant_cyc = cyc;
      end

      tick();

      exp_valid = m_pending && (cyc >= m_grant_cyc + 1);
      chk($sformatf("rnd%0d_gnt", cyc), 32'(bus.gnt), 32'(exp_gnt));
      chk($sformatf("rnd%0d_busy", cyc), 32'(bus.busy), 32'(m_pending));
      chk($sformatf("rnd%0d_valid", cyc), 32'(bus.out_valid), 32'(exp_valid));
      if (exp_valid && exp_q.size() > 0) begin
        chk($sformatf("rnd%0d_bin", cyc), 32'(bus.out_bin), 32'(exp_q[0]));
        chk($sformatf("rnd%0d_id", cyc), 32'(bus.out_id), 32'(exp_id_q[0]));
      end

      // Requesters keep req and code stable until granted.
      for (int i = 0; i < N; i++) begin
        if (exp_gnt[i]) begin
          bus.req[i] = ($urandom_range(0, 1) == 1);
          g = W'($urandom);
          set_slice(i, g);
        end else if (!bus.req[i]) begin
          bus.req[i] = ($urandom_range(0, 2) == 0);
          g = W'($urandom);
          set_slice(i, g);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
